// File: rtl/rv32i_types.sv
// Shared RV32 types for the multiply/divide unit.
// Op encodings follow funct3 of the M extension.
package rv32i_types;
  localparam int ROB_W  = 5;
  localparam int PREG_W = 6;

  typedef enum logic [2:0] {
    mul_f3_mul    = 3'd0,
    mul_f3_mulh   = 3'd1,
    mul_f3_mulhsu = 3'd2,
    mul_f3_mulhu  = 3'd3,
    mul_f3_div    = 3'd4,
    mul_f3_divu   = 3'd5,
    mul_f3_rem    = 3'd6,
    mul_f3_remu   = 3'd7
  } mul_f3_t;

  typedef struct packed {
    mul_f3_t           op;
    logic [ROB_W-1:0]  rob_index;
    logic [4:0]        rd;
    logic [PREG_W-1:0] pd;
  } reservation_station_entry_t;

  typedef struct packed {
    logic [31:0]       result;
    logic [ROB_W-1:0]  rob_index;
    logic [4:0]        areg_index;
    logic [PREG_W-1:0] preg_index;
    logic              cdb_valid;
  } cdb_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

  function automatic logic is_mul_op(input mul_f3_t op);
    return !op[2];
  endfunction
endpackage

// File: rtl/muldiv_unit_if.sv
// Start/busy/done handshake between the unit
// and its iterative divider.
interface muldiv_unit_if;
  import rv32i_types::*;
  logic        start;
  mul_f3_t     op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, op, a, b,
    input  busy, done, result
  );
  modport slave (
    input  start, op, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_div_iter.sv
// Radix-2 restoring divider, one op at a time,
// fixed 34-cycle start-to-write latency.
module muldiv_div_iter
  import rv32i_types::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  muldiv_unit_if.slave div
);
  div_state_t  state, state_nx;
  logic [4:0]  cnt;
  logic        sgn, rem_op, neg_q, neg_r, dz, ovf;
  logic [31:0] a_raw, dvsr, q, r, res, fix;
  logic [31:0] a_mag, b_mag, diff;
  logic [32:0] r_sh;
  logic        ge;

  assign sgn = (div.op == mul_f3_div) ||
               (div.op == mul_f3_rem);
  assign a_mag = (sgn && div.a[31]) ? -div.a : div.a;
  assign b_mag = (sgn && div.b[31]) ? -div.b : div.b;

  assign r_sh = {r, q[31]};
  assign ge   = r_sh >= {1'b0, dvsr};
  assign diff = r_sh[31:0] - dvsr;

  assign div.busy   = state != DIV_IDLE;
  assign div.done   = state == DIV_DONE;
  assign div.result = res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == DIV_RUN) ? cnt + 5'd1 : '0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      DIV_IDLE: if (div.start) state_nx = DIV_RUN;
      DIV_RUN:  if (cnt == 5'd31) state_nx = DIV_FIX;
      DIV_FIX:  state_nx = DIV_DONE;
      DIV_DONE: state_nx = DIV_IDLE;
      default:  state_nx = DIV_IDLE;
    endcase
    if (flush) state_nx = DIV_IDLE;
  end

  // Special cases skip the iterations but keep the slot timing.
  always_comb begin
    fix = '0;
    unique case (1'b1)
      dz:      fix = rem_op ? a_raw : '1;
      ovf:     fix = rem_op ? '0 : 32'h8000_0000;
      default: fix = rem_op ? (neg_r ? -r : r)
                            : (neg_q ? -q : q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == DIV_IDLE) begin
      a_raw  <= div.a;
      dvsr   <= b_mag;
      q      <= a_mag;
      r      <= '0;
      rem_op <= (div.op == mul_f3_rem) ||
                (div.op == mul_f3_remu);
      neg_q  <= sgn && (div.a[31] ^ div.b[31]);
      neg_r  <= sgn && div.a[31];
      dz     <= div.b == '0;
      ovf    <= sgn && (div.a == 32'h8000_0000) &&
                (div.b == 32'hFFFF_FFFF);
    end else if (state == DIV_RUN) begin
      if (!(dz || ovf)) begin
        q <= {q[30:0], ge};
        r <= ge ? diff : r_sh[31:0];
      end
    end else if (state == DIV_FIX) begin
      res <= fix;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute unit: pipelined multiplier, iterative
// divider and a credit-managed result FIFO onto the CDB.
module muldiv_unit
  import rv32i_types::*;
#(
  parameter int MUL_STAGES = 4,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  reservation_station_entry_t issue_entry,
  input  logic [31:0]                issue_ps1_v,
  input  logic [31:0]                issue_ps2_v,
  output logic                       cdb_valid,
  input  logic                       cdb_ready,
  output cdb_t                       cdb_out,
  input  logic                       branch_flush
);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + MUL_STAGES + 2);

  muldiv_unit_if dif ();

  logic                       accept, is_mul;
  logic [MUL_STAGES-1:0]      mv;
  logic [63:0]                mp [MUL_STAGES];
  reservation_station_entry_t mt [MUL_STAGES];
  reservation_station_entry_t dtag;
  logic [63:0]                ma, mb, prod;
  logic                       s1, s2;
  cdb_t                       fifo [OUT_DEPTH];
  logic [PW-1:0]              wp, rp;
  logic [CW-1:0]              count, mcnt, credits;
  logic                       mul_wr, div_wr, pop;
  cdb_t                       mul_res, div_res;

  function automatic logic [PW-1:0] adv(
    input logic [PW-1:0] p,
    input logic [1:0]    n
  );
    int s;
    s = int'(p) + int'(n);
    if (s >= OUT_DEPTH) s -= OUT_DEPTH;
    return PW'(s);
  endfunction

  assign is_mul = is_mul_op(issue_entry.op);

  always_comb begin
    mcnt = '0;
    for (int i = 0; i < MUL_STAGES; i++)
      mcnt = mcnt + CW'(mv[i]);
  end

  // Every credit is a reserved FIFO slot, so writes never overflow.
  assign credits = mcnt + CW'(dif.busy) + count;
  assign issue_ready = !branch_flush &&
                       (credits < CW'(OUT_DEPTH)) &&
                       (is_mul || !dif.busy);
  assign accept = issue_valid && issue_ready;

  assign s1 = issue_ps1_v[31] &&
              (issue_entry.op != mul_f3_mulhu);
  assign s2 = issue_ps2_v[31] &&
              ((issue_entry.op == mul_f3_mul) ||
               (issue_entry.op == mul_f3_mulh));
  assign ma   = {{32{s1}}, issue_ps1_v};
  assign mb   = {{32{s2}}, issue_ps2_v};
  assign prod = ma * mb;

  assign dif.start = accept && !is_mul;
  assign dif.op    = issue_entry.op;
  assign dif.a     = issue_ps1_v;
  assign dif.b     = issue_ps2_v;

  muldiv_div_iter u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (branch_flush),
    .div   (dif)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mv <= '0;
    else if (branch_flush)
      mv <= '0;
    else
      mv <= {mv[MUL_STAGES-2:0], accept && is_mul};
  end

  always_ff @(posedge clk) begin
    mp[0] <= prod;
    mt[0] <= issue_entry;
    for (int i = 1; i < MUL_STAGES; i++) begin
      mp[i] <= mp[i-1];
      mt[i] <= mt[i-1];
    end
    if (dif.start) dtag <= issue_entry;
  end

  always_comb begin
    mul_res            = '0;
    mul_res.result     = (mt[MUL_STAGES-1].op == mul_f3_mul)
                         ? mp[MUL_STAGES-1][31:0]
                         : mp[MUL_STAGES-1][63:32];
    mul_res.rob_index  = mt[MUL_STAGES-1].rob_index;
    mul_res.areg_index = mt[MUL_STAGES-1].rd;
    mul_res.preg_index = mt[MUL_STAGES-1].pd;
    mul_res.cdb_valid  = 1'b1;
    div_res            = '0;
    div_res.result     = dif.result;
    div_res.rob_index  = dtag.rob_index;
    div_res.areg_index = dtag.rd;
    div_res.preg_index = dtag.pd;
    div_res.cdb_valid  = 1'b1;
  end

  assign mul_wr    = mv[MUL_STAGES-1];
  assign div_wr    = dif.done;
  assign cdb_valid = count != '0;
  assign pop       = cdb_valid && cdb_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (branch_flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= adv(wp, {1'b0, mul_wr} + {1'b0, div_wr});
      rp    <= adv(rp, {1'b0, pop});
      count <= count + CW'(mul_wr) + CW'(div_wr)
               - CW'(pop);
    end
  end

  // Multiply takes the lower slot when both finish together.
  always_ff @(posedge clk) begin
    if (mul_wr) fifo[wp] <= mul_res;
    if (div_wr) fifo[mul_wr ? adv(wp, 2'd1) : wp] <= div_res;
  end

  always_comb begin
    cdb_out = '0;
    if (cdb_valid) begin
      cdb_out           = fifo[rp];
      cdb_out.cdb_valid = 1'b1;
    end
  end
endmodule
